// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: OFF/ON/BLINK/BREATH patterns with a PWM breathing ramp.
// New settings arrive over valid/ready and take effect only at pattern-cycle boundaries.
module led_seq_ctrl #(
    parameter int STEP_MAX = 15,
    parameter int LVL_W    = 4,
    parameter int PRE_W    = 8
) (
    input  logic             clk_s,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_mask,
    input  logic [PRE_W-1:0] cfg_period,
    output logic [7:0]       led,
    output logic [LVL_W-1:0] level,
    output logic             cycle_done
);
    // state | meaning
    // IDLE  | static OFF/ON drive; any pending config is applied on the next clock
    // BLINK | square wave, phase toggles every tick
    // UP    | breath ramp rising one level per tick
    // DOWN  | breath ramp falling; a tick at level 0 ends the pattern cycle

    localparam logic [1:0]       MODE_ON     = 2'd1;
    localparam logic [1:0]       MODE_BLINK  = 2'd2;
    localparam logic [1:0]       MODE_BREATH = 2'd3;
    localparam logic [LVL_W-1:0] LVL_MAX     = LVL_W'(STEP_MAX);
    localparam logic [LVL_W-1:0] PWM_LAST    = LVL_W'(STEP_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLINK, S_UP, S_DOWN} state_t;

    state_t            state;
    logic [LVL_W-1:0]  pwm_cnt;
    logic [PRE_W-1:0]  pre_cnt;
    logic              phase;
    logic              pend;
    logic [1:0]        pend_mode;
    logic [7:0]        pend_mask;
    logic [PRE_W-1:0]  pend_period;
    logic [1:0]        act_mode;
    logic [7:0]        act_mask;
    logic [PRE_W-1:0]  act_period;

    logic frame_end;
    logic tick;
    logic cycle_end;
    logic apply;
    logic accept;
    logic on;

    function automatic state_t mode_state(input logic [1:0] m);
        state_t s;
        case (m)
            MODE_BLINK:  s = S_BLINK;
            MODE_BREATH: s = S_UP;
            default:     s = S_IDLE;
        endcase
        return s;
    endfunction

    assign frame_end = (pwm_cnt == PWM_LAST);
    assign tick      = frame_end && (pre_cnt == act_period);
    assign cycle_end = tick && (((state == S_BLINK) && phase) ||
                                ((state == S_DOWN) && (level == '0)));
    assign apply     = en && pend && ((state == S_IDLE) || cycle_end);
    assign accept    = cfg_valid && !pend;
    assign cfg_ready = !pend;

    always_comb begin
        on = 1'b0;
        case (state)
            S_IDLE:  on = (act_mode == MODE_ON);
            S_BLINK: on = phase;
            default: on = (pwm_cnt < level);
        endcase
    end

    always_ff @(posedge clk_s or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pwm_cnt     <= '0;
            pre_cnt     <= '0;
            phase       <= 1'b0;
            level       <= '0;
            led         <= 8'h00;
            cycle_done  <= 1'b0;
            pend        <= 1'b0;
            pend_mode   <= 2'd0;
            pend_mask   <= 8'hFF;
            pend_period <= '0;
            act_mode    <= 2'd0;
            act_mask    <= 8'hFF;
            act_period  <= '0;
        end else begin
            pwm_cnt    <= frame_end ? '0 : pwm_cnt + LVL_W'(1);
            cycle_done <= 1'b0;

            if (accept) begin
                pend        <= 1'b1;
                pend_mode   <= cfg_mode;
                pend_mask   <= cfg_mask;
                pend_period <= cfg_period;
            end

            if (!en) begin
                state   <= S_IDLE;
                level   <= '0;
                phase   <= 1'b0;
                pre_cnt <= '0;
                led     <= 8'h00;
            end else begin
                led <= act_mask & {8{on}};
                if (frame_end)
                    pre_cnt <= (pre_cnt == act_period) ? '0 : pre_cnt + PRE_W'(1);

                case (state)
                    // resuming after en returns picks the pattern back up from its start
                    S_IDLE:  state <= mode_state(act_mode);
                    S_BLINK: if (tick) phase <= ~phase;
                    S_UP: begin
                        if (tick) begin
                            if (level == LVL_MAX) state <= S_DOWN;
                            else                  level <= level + LVL_W'(1);
                        end
                    end
                    S_DOWN: begin
                        if (tick) begin
                            if (level == '0) state <= S_UP;
                            else             level <= level - LVL_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase

                if (cycle_end)
                    cycle_done <= 1'b1;

                if (apply) begin
                    pend       <= 1'b0;
                    act_mode   <= pend_mode;
                    act_mask   <= pend_mask;
                    act_period <= pend_period;
                    pre_cnt    <= '0;
                    level      <= '0;
                    phase      <= 1'b0;
                    state      <= mode_state(pend_mode);
                end
            end
        end
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus random traffic, all checked
// every clock against a pattern-step reference model.
module tb_led_seq_ctrl;
    localparam int STEP = 15;

    logic       clk_s = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_mode = 2'd0;
    logic [7:0] cfg_mask = 8'h00;
    logic [7:0] cfg_period = 8'h00;
    logic [7:0] led;
    logic [3:0] level;
    logic       cycle_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_s = ~clk_s;

    led_seq_ctrl dut (
        .clk_s(clk_s), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_mask(cfg_mask), .cfg_period(cfg_period),
        .led(led), .level(level), .cycle_done(cycle_done)
    );

    // Reference model: a pattern is a sequence of tick-indexed steps.
    // Breath step 0..31 maps to level 0..15,15..0; blink step 0/1 is dark/lit.
    int         m_clk, m_frames, m_step, m_period, p_period;
    bit         m_pend, m_run, m_cdone;
    logic [1:0] m_mode, p_mode;
    logic [7:0] m_mask, p_mask, m_led;

    function automatic int lvl_of(input int s);
        return (s <= STEP) ? s : (2 * STEP + 1 - s);
    endfunction

    function logic [3:0] exp_level();
        return (m_run && m_mode == 2'd3) ? 4'(lvl_of(m_step)) : 4'd0;
    endfunction

    function logic [13:0] exp_vec();
        return {m_led, exp_level(), m_cdone, ~m_pend};
    endfunction

    task automatic model_reset();
        m_clk = 0; m_frames = 0; m_step = 0; m_pend = 0; m_run = 0; m_cdone = 0;
        m_mode = 2'd0; m_mask = 8'hFF; m_period = 0; m_led = 8'h00;
        p_mode = 2'd0; p_mask = 8'hFF; p_period = 0;
    endtask

    task automatic model_step();
        int  pwm, last;
        bit  fe, tk, on, acc, do_apply;
        pwm = m_clk % STEP;
        fe  = (pwm == STEP - 1);
        tk  = fe && ((m_frames % (m_period + 1)) == m_period);
        acc = cfg_valid && !m_pend;
        if (!m_run)              on = (m_mode == 2'd1);
        else if (m_mode == 2'd2) on = (m_step == 1);
        else                     on = (pwm < lvl_of(m_step));
        m_led    = en ? (m_mask & {8{on}}) : 8'h00;
        m_cdone  = 0;
        do_apply = 0;
        if (!en) begin
            m_run = 0; m_step = 0; m_frames = 0;
        end else begin
            if (fe) m_frames++;
            if (!m_run) begin
                if (m_pend) do_apply = 1;
                else        m_run = (m_mode >= 2'd2);
            end else if (tk) begin
                last = (m_mode == 2'd2) ? 1 : 2 * STEP + 1;
                if (m_step == last) begin
                    m_cdone = 1; m_step = 0; do_apply = m_pend;
                end else begin
                    m_step++;
                end
            end
            if (do_apply) begin
                m_mode = p_mode; m_mask = p_mask; m_period = p_period;
                m_pend = 0; m_run = (p_mode >= 2'd2); m_step = 0; m_frames = 0;
            end
        end
        if (acc) begin
            m_pend = 1; p_mode = cfg_mode; p_mask = cfg_mask; p_period = int'(cfg_period);
        end
        m_clk++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_s);
        @(negedge clk_s);
    endtask

    task automatic send_cfg(input logic [1:0] mode, input logic [7:0] mask, input logic [7:0] period);
        cfg_valid = 1'b1; cfg_mode = mode; cfg_mask = mask; cfg_period = period;
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        model_reset();
        @(negedge clk_s); @(negedge clk_s);
        vectors++;
        if ({led, level, cycle_done, cfg_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset: got led=%h lvl=%0d cd=%b rdy=%b, want 00/0/0/1", led, level, cycle_done, cfg_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_breath();
        logic [13:0] obs;
        int cds[$];
        en = 1'b1;
        send_cfg(2'd3, 8'hFF, 8'd0);
        for (int i = 0; i < 1000; i++) begin
            cycle();
            obs = {led, level, cycle_done, cfg_ready};
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL breath t=%0t got=%h want=%h", $time, obs, exp_vec());
            end
            if (cycle_done) cds.push_back(i);
        end
        vectors++;
        if (cds.size() < 2 || (cds[1] - cds[0]) != 480) begin
            miscompares++;
            $display("FAIL breath_period: got %0d pulses, gap %0d, want gap 480", cds.size(),
                     (cds.size() >= 2) ? cds[1] - cds[0] : -1);
        end
    endtask

    task automatic test_mid_ramp();
        logic [13:0] obs;
        bit found = 0;
        for (int i = 0; i < 100; i++) cycle();
        send_cfg(2'd1, 8'hFF, 8'd0);
        for (int i = 0; i < 600 && !found; i++) begin
            cycle();
            obs = {led, level, cycle_done, cfg_ready};
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL mid_ramp t=%0t got=%h want=%h", $time, obs, exp_vec());
            end
            if (cycle_done) found = 1;
            else if (cfg_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_ramp_ready: got %b want 0 while pending", cfg_ready);
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_ramp_timeout: no cycle_done within 600 clocks, want one");
        end else begin
            cycle();
            if (led !== 8'hFF) begin
                miscompares++;
                $display("FAIL mid_ramp_on: got led=%h want ff", led);
            end
        end
    endtask

    task automatic test_blink();
        logic [13:0] obs;
        logic [7:0]  prev;
        int chg[$];
        int cds[$];
        send_cfg(2'd2, 8'h0F, 8'd1);
        prev = led;
        for (int i = 0; i < 220; i++) begin
            cycle();
            obs = {led, level, cycle_done, cfg_ready};
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL blink t=%0t got=%h want=%h", $time, obs, exp_vec());
            end
            if (led !== prev) chg.push_back(i);
            if (cycle_done) cds.push_back(i);
            prev = led;
        end
        vectors++;
        if (chg.size() < 4 || (chg[2] - chg[1]) != 30 || (chg[3] - chg[2]) != 30) begin
            miscompares++;
            $display("FAIL blink_toggle: %0d toggles seen, want spacing 30", chg.size());
        end
        vectors++;
        if (cds.size() < 2 || (cds[1] - cds[0]) != 60) begin
            miscompares++;
            $display("FAIL blink_cycle: %0d pulses seen, want spacing 60", cds.size());
        end
    endtask

    task automatic test_idle_latency();
        logic [13:0] obs;
        send_cfg(2'd0, 8'hFF, 8'd0);
        for (int i = 0; i < 100; i++) begin
            cycle();
            obs = {led, level, cycle_done, cfg_ready};
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL idle_off t=%0t got=%h want=%h", $time, obs, exp_vec());
            end
        end
        send_cfg(2'd1, 8'hA5, 8'd0);
        cycle();
        vectors++;
        if (led !== 8'h00) begin
            miscompares++;
            $display("FAIL idle_n1: got led=%h want 00", led);
        end
        cycle();
        vectors++;
        if (led !== 8'hA5) begin
            miscompares++;
            $display("FAIL idle_n2: got led=%h want a5", led);
        end
    endtask

    task automatic test_en_drop();
        logic [13:0] obs;
        bit seen_top = 0, hit = 0;
        send_cfg(2'd3, 8'hFF, 8'd0);
        for (int i = 0; i < 600 && !hit; i++) begin
            cycle();
            obs = {led, level, cycle_done, cfg_ready};
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL en_ramp t=%0t got=%h want=%h", $time, obs, exp_vec());
            end
            if (level == 4'd15) seen_top = 1;
            if (seen_top && level == 4'd8) hit = 1;
        end
        en = 1'b0;
        cycle();
        vectors++;
        if (!hit || led !== 8'h00 || level !== 4'd0) begin
            miscompares++;
            $display("FAIL en_drop: reached=%b got led=%h lvl=%0d want 00/0", hit, led, level);
        end
        for (int i = 0; i < 40; i++) begin
            if (i == 20) en = 1'b1;
            cycle();
            obs = {led, level, cycle_done, cfg_ready};
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL en_resume t=%0t got=%h want=%h", $time, obs, exp_vec());
            end
        end
    endtask

    task automatic test_rst_blink();
        logic [13:0] obs;
        send_cfg(2'd2, 8'h3C, 8'd0);
        for (int i = 0; i < 700 && !cfg_ready; i++) cycle();
        send_cfg(2'd3, 8'hFF, 8'd0);
        for (int i = 0; i < 5; i++) cycle();
        vectors++;
        if (cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pend: got cfg_ready=%b want 0 before reset", cfg_ready);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({led, level, cycle_done, cfg_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_mid: got led=%h lvl=%0d cd=%b rdy=%b, want 00/0/0/1", led, level, cycle_done, cfg_ready);
        end
        model_reset();
        @(negedge clk_s);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            obs = {led, level, cycle_done, cfg_ready};
            vectors++;
            if (obs !== exp_vec() || led !== 8'h00) begin
                miscompares++;
                $display("FAIL rst_after t=%0t got=%h want=%h", $time, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] obs;
        int low_left = 0;
        for (int i = 0; i < 4000; i++) begin
            cfg_valid  = ($urandom_range(0, 15) == 0);
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_mask   = 8'($urandom);
            cfg_period = 8'($urandom_range(0, 2));
            if (low_left > 0) begin
                low_left--;
                en = (low_left == 0);
            end else if ($urandom_range(0, 199) == 0) begin
                low_left = $urandom_range(1, 40);
                en = 1'b0;
            end
            cycle();
            obs = {led, level, cycle_done, cfg_ready};
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random t=%0t got=%h want=%h", $time, obs, exp_vec());
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_breath();
        test_mid_ramp();
        test_blink();
        test_idle_latency();
        test_en_drop();
        test_rst_blink();
        en = 1'b1;
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
